// File: rtl/wb_led_pwm_if.sv
// Wishbone-style register bus between a controller and the LED PWM peripheral.
// Handshake: every cycle with wb_stb=1 is one request; the responder pulses wb_ack
// exactly one cycle later with no wait states, and wb_dat_p is valid only with wb_ack.
interface wb_led_pwm_if;
    logic       wb_stb;
    logic       wb_we;
    logic [3:0] wb_adr;
    logic [7:0] wb_dat_c;
    logic       wb_ack;
    logic [7:0] wb_dat_p;

    modport master (
        output wb_stb,
        output wb_we,
        output wb_adr,
        output wb_dat_c,
        input  wb_ack,
        input  wb_dat_p
    );

    modport slave (
        input  wb_stb,
        input  wb_we,
        input  wb_adr,
        input  wb_dat_c,
        output wb_ack,
        output wb_dat_p
    );
endinterface

// File: rtl/wb_led_pwm.sv
// Bus-programmed LED driver: per-LED 8-bit PWM duty with glitch-free period reloads,
// a shared step prescaler and an optional blink gate.
module wb_led_pwm #(
    parameter int pLeds     = 8,
    parameter int pBlinkDiv = 16
) (
    input  logic             clk,
    input  logic             rst,
    wb_led_pwm_if.slave      bus,
    output logic [pLeds-1:0] leds
);
    localparam int BlinkW = (pBlinkDiv > 1) ? $clog2(pBlinkDiv) : 1;
    localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(pBlinkDiv - 1);

    logic [1:0]        ctrl;
    logic [7:0]        prescale;
    logic [7:0]        duty_shadow [pLeds];
    logic [7:0]        duty_active [pLeds];
    logic [7:0]        pre_cnt;
    logic [7:0]        pwm_cnt;
    logic [BlinkW-1:0] blink_cnt;
    logic              blink_ph;

    logic       en;
    logic       wr;
    logic       en_rise;
    logic       tick;
    logic       period_start;
    logic       wrap;
    logic [7:0] rd_data;

    assign en           = ctrl[0];
    assign wr           = bus.wb_stb && bus.wb_we;
    assign en_rise      = wr && (bus.wb_adr == 4'h0) && bus.wb_dat_c[0] && !en;
    assign tick         = en && (pre_cnt >= prescale);
    assign period_start = tick && (pwm_cnt == 8'h00);
    assign wrap         = tick && (pwm_cnt == 8'hFF);

    always_comb begin
        rd_data = 8'h00;
        if (bus.wb_adr == 4'h0) begin
            rd_data = {6'b0, ctrl};
        end else if (bus.wb_adr == 4'h1) begin
            rd_data = prescale;
        end
        for (int i = 0; i < pLeds; i++) begin
            if (bus.wb_adr == 4'(i + 2)) begin
                rd_data = duty_shadow[i];
            end
        end
    end

    // Reads return the register contents seen in the strobe cycle, so a read right
    // after a write already observes the written value.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.wb_ack   <= 1'b0;
            bus.wb_dat_p <= 8'h00;
        end else begin
            bus.wb_ack   <= bus.wb_stb;
            bus.wb_dat_p <= (bus.wb_stb && !bus.wb_we) ? rd_data : 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl     <= 2'b00;
            prescale <= 8'h00;
            for (int i = 0; i < pLeds; i++) begin
                duty_shadow[i] <= 8'h00;
            end
        end else if (wr) begin
            if (bus.wb_adr == 4'h0) begin
                ctrl <= bus.wb_dat_c[1:0];
            end
            if (bus.wb_adr == 4'h1) begin
                prescale <= bus.wb_dat_c;
            end
            for (int i = 0; i < pLeds; i++) begin
                if (bus.wb_adr == 4'(i + 2)) begin
                    duty_shadow[i] <= bus.wb_dat_c;
                end
            end
        end
    end

    // Active duties change only at a period boundary or at enable; a shadow write in
    // the same cycle is picked up at the following boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < pLeds; i++) begin
                duty_active[i] <= 8'h00;
            end
        end else if (en_rise || period_start) begin
            for (int i = 0; i < pLeds; i++) begin
                duty_active[i] <= duty_shadow[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            pre_cnt   <= 8'h00;
            pwm_cnt   <= 8'h00;
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else begin
            pre_cnt <= tick ? 8'h00 : pre_cnt + 8'h01;
            if (tick) begin
                pwm_cnt <= pwm_cnt + 8'h01;
            end
            if (wrap) begin
                if (blink_cnt == BlinkLast) begin
                    blink_cnt <= '0;
                    blink_ph  <= !blink_ph;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            leds <= '0;
        end else begin
            for (int i = 0; i < pLeds; i++) begin
                leds[i] <= en && (pwm_cnt < duty_active[i]) && (!ctrl[1] || blink_ph);
            end
        end
    end
endmodule

// File: doc/wb_led_pwm.md
Name: wb_led_pwm

Overview:
- Wishbone responder that drives LEDs with per-LED 8-bit PWM brightness and an optional blink gate.
- Sits on the peripheral side of the Wishbone bus and answers the controller's strobes with acks and read data.
- Gives the team a bus-driven LED output to complement the passive bus monitor.

Parameters:
pLeds, 8, number of LED outputs / duty registers (1..14)
pBlinkDiv, 16, PWM periods per blink phase toggle (>=1)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
wb_stb  input  1  request strobe; each high cycle is one request
wb_we  input  1  1 = write, 0 = read
wb_adr  input  4  register address
wb_dat_c  input  8  write data, controller to peripheral
wb_ack  output  1  acknowledge, one-cycle pulse per request
wb_dat_p  output  8  read data, valid when wb_ack=1
leds  output  pLeds  LED drive, registered

Behaviour:
- Register map (8-bit):
  - 0x0 CTRL: bit0 EN, bit1 BLINK; bits 7:2 read 0.
  - 0x1 PRESCALE: clock cycles per PWM step, minus 1.
  - 0x2+i DUTY[i], for i < pLeds.
  - All other addresses read 0x00; writes to them are ignored but still acked.
- Handshake:
  - wb_stb sampled at cycle N produces wb_ack=1 at N+1 for exactly one cycle.
  - For reads, wb_dat_p carries the register value as sampled at N.
  - Back-to-back strobes produce back-to-back acks; there is no wait state.
  - A write takes effect at N+1.
  - A read at N+1 of an address written at N returns the new value.
  - wb_dat_p = 0 when wb_ack=0.
- Duty shadowing:
  - DUTY writes land in a shadow register; reads return the shadow.
  - active_duty[i] is loaded from the shadow on every cycle where pwm_cnt==0 and a step tick occurs, and on the EN 0->1 transition.
  - Result: duty changes never glitch mid-period.
- Prescaler:
  - pre_cnt counts up each cycle while EN=1.
  - When pre_cnt >= PRESCALE: tick=1 and pre_cnt <= 0.
  - The >= comparison keeps lowering PRESCALE mid-count safe, with no overflow wait.
- PWM counter: 8-bit pwm_cnt increments on tick and wraps 255->0. One PWM period = 256 ticks.
- Blink:
  - blink_cnt counts PWM wraps (255->0 on tick).
  - At pBlinkDiv wraps, blink_cnt is cleared and blink_ph toggles.
  - Counting occurs only while EN=1.
- LED output, registered from the current-cycle state:
  - leds[i] <= EN && (pwm_cnt < active_duty[i]) && (!BLINK || blink_ph).
  - Duty 0 = always off; duty 255 = on 255 of 256 steps.
- Disable: EN=0 holds pre_cnt, pwm_cnt, blink_cnt and blink_ph at 0; leds go 0 on the next cycle.
- Enable: EN 0->1 starts a fresh period with pwm_cnt=0 and active duties reloaded.
- Reset values: wb_ack=0, wb_dat_p=0, leds=0; CTRL, PRESCALE, all DUTY shadows, active duties, pre_cnt, pwm_cnt, blink_cnt and blink_ph all 0.
- Reset mid-operation:
  - Reset takes priority over a same-cycle strobe; no ack is generated for a strobe sampled with rst=1.
  - A pending ack is cleared.
- Write and read of the same register on consecutive cycles are covered by the handshake rule.
- Simultaneous DUTY write and period reload: the reload takes the old shadow; the new value applies from the next period.

Test Plan:
- Reset -> leds=0, wb_ack=0, and reads of 0x0–0x9 all return 0x00.
- Write 0x5A to 0x3, then read 0x3 on the next cycle -> acks at N+1 and N+2, second ack has wb_dat_p=0x5A.
- Back-to-back reads of 0x1 and 0xF -> consecutive ack cycles returning PRESCALE and then 0x00.
- PRESCALE=0, DUTY[0]=64, CTRL=0x01 -> over each 256-cycle period, leds[0] is high exactly 64 cycles, starting one cycle after enable.
- Write DUTY[0]=128 at pwm_cnt=10 of a duty-64 period -> this period high 64 cycles, next period high 128 cycles.
- BLINK=1, pBlinkDiv=2, PRESCALE=0, DUTY[1]=255 -> leds[1] fully off for 512 cycles, then PWM-active for 512 cycles.
- Assert rst mid-period together with a strobe -> no ack, leds=0 the next cycle, all registers read 0.
